// File: rtl/maze_controller.sv
// Maze game core: moves a player around a fixed 16x12-cell maze, counts goals,
// and colours each VGA pixel from the raw display counters.
module maze_controller #(
    parameter int H_OFFSET = 144,
    parameter int V_OFFSET = 35,
    parameter int CELL     = 40
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        move_clk,
    input  logic        bright,
    input  logic [9:0]  hCount,
    input  logic [9:0]  vCount,
    input  logic        Up,
    input  logic        Down,
    input  logic        Left,
    input  logic        Right,
    output logic [11:0] rgb,
    output logic [3:0]  score
);

    localparam logic [3:0] START_COL = 4'd1;
    localparam logic [3:0] START_ROW = 4'd1;
    localparam logic [3:0] GOAL_COL  = 4'd14;
    localparam logic [3:0] GOAL_ROW  = 4'd10;

    // Bit 15 of each row word is column 0; rows past the bottom read as solid wall.
    function automatic logic [15:0] maze_row(input logic [3:0] r);
        case (r)
            4'd0:    maze_row = 16'hFFFF;
            4'd1:    maze_row = 16'h8001;
            4'd2:    maze_row = 16'hBFBD;
            4'd3:    maze_row = 16'h8001;
            4'd4:    maze_row = 16'hFDFF;
            4'd5:    maze_row = 16'h8001;
            4'd6:    maze_row = 16'hBFFD;
            4'd7:    maze_row = 16'h8001;
            4'd8:    maze_row = 16'hFFBF;
            4'd9:    maze_row = 16'h8001;
            4'd10:   maze_row = 16'h8001;
            default: maze_row = 16'hFFFF;
        endcase
    endfunction

    function automatic logic is_wall(input logic [3:0] c, input logic [3:0] r);
        logic [15:0] w;
        w       = maze_row(r);
        is_wall = w[4'd15 - c];
    endfunction

    logic        move_sync;
    logic        move_prev;
    logic        tick;
    logic [3:0]  buttons;
    logic [3:0]  btn_hist;
    logic [3:0]  pressed;
    logic [3:0]  player_col;
    logic [3:0]  player_row;
    logic [3:0]  tgt_col;
    logic [3:0]  tgt_row;
    logic        tgt_valid;
    logic        can_move;

    assign tick    = move_sync & ~move_prev;
    assign buttons = {Up, Down, Left, Right};
    assign pressed = buttons & ~btn_hist;

    // Highest-priority new press picks the direction even if that move is then blocked.
    always_comb begin
        tgt_col   = player_col;
        tgt_row   = player_row;
        tgt_valid = 1'b0;
        if (pressed[3]) begin
            if (player_row != 4'd0) begin
                tgt_row   = player_row - 4'd1;
                tgt_valid = 1'b1;
            end
        end else if (pressed[2]) begin
            if (player_row != 4'd11) begin
                tgt_row   = player_row + 4'd1;
                tgt_valid = 1'b1;
            end
        end else if (pressed[1]) begin
            if (player_col != 4'd0) begin
                tgt_col   = player_col - 4'd1;
                tgt_valid = 1'b1;
            end
        end else if (pressed[0]) begin
            if (player_col != 4'd15) begin
                tgt_col   = player_col + 4'd1;
                tgt_valid = 1'b1;
            end
        end
    end

    assign can_move = tick && tgt_valid && !is_wall(tgt_col, tgt_row);

    logic [9:0]  px;
    logic [9:0]  py;
    logic [9:0]  ox;
    logic [9:0]  oy;
    logic [3:0]  pix_col;
    logic [3:0]  pix_row;
    logic [11:0] pix_rgb;

    // Compare chains give floor(x/CELL) without a divider.
    always_comb begin
        px      = hCount - 10'(H_OFFSET);
        py      = vCount - 10'(V_OFFSET);
        pix_col = 4'd0;
        pix_row = 4'd0;
        for (int i = 1; i < 16; i++) begin
            if (px >= 10'(i * CELL)) pix_col = 4'(i);
        end
        for (int i = 1; i < 12; i++) begin
            if (py >= 10'(i * CELL)) pix_row = 4'(i);
        end
        ox = px - 10'(int'(pix_col) * CELL);
        oy = py - 10'(int'(pix_row) * CELL);

        if (!bright)
            pix_rgb = 12'h000;
        else if (pix_col == player_col && pix_row == player_row &&
                 ox >= 10'd8 && ox < 10'd32 && oy >= 10'd8 && oy < 10'd32)
            pix_rgb = 12'hF00;
        else if (pix_col == GOAL_COL && pix_row == GOAL_ROW)
            pix_rgb = 12'h0F0;
        else if (is_wall(pix_col, pix_row))
            pix_rgb = 12'h00F;
        else
            pix_rgb = 12'hFFF;
    end

    // Reaching the goal sends the player straight back to the start in the same edge.
    always_ff @(posedge clk) begin
        if (Reset) begin
            move_sync  <= 1'b0;
            move_prev  <= 1'b0;
            btn_hist   <= 4'd0;
            player_col <= START_COL;
            player_row <= START_ROW;
            score      <= 4'd0;
            rgb        <= 12'h000;
        end else begin
            move_sync <= move_clk;
            move_prev <= move_sync;
            rgb       <= pix_rgb;
            if (tick) btn_hist <= buttons;
            if (can_move) begin
                if (tgt_col == GOAL_COL && tgt_row == GOAL_ROW) begin
                    player_col <= START_COL;
                    player_row <= START_ROW;
                    score      <= score + 4'd1;
                end else begin
                    player_col <= tgt_col;
                    player_row <= tgt_row;
                end
            end
        end
    end

endmodule

// File: tb/tb_maze_controller.sv
// Directed bench for maze_controller: button presses drive the player, and the
// rendered pixel colour plus score are checked through an expectation queue.
module tb_maze_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        move_clk;
    logic        bright;
    logic [9:0]  hCount;
    logic [9:0]  vCount;
    logic        Up, Down, Left, Right;
    logic [11:0] rgb;
    logic [3:0]  score;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [11:0] rgb;
        logic [3:0]  score;
        string       name;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [3:0] dir;
        int         steps;
    } leg_t;
    leg_t goal_path [9];

    localparam logic [3:0] BTN_NONE = 4'b0000;
    localparam logic [3:0] BTN_UP   = 4'b1000;
    localparam logic [3:0] BTN_DN   = 4'b0100;
    localparam logic [3:0] BTN_LF   = 4'b0010;
    localparam logic [3:0] BTN_RT   = 4'b0001;

    maze_controller dut (
        .clk      (clk),
        .Reset    (reset),
        .move_clk (move_clk),
        .bright   (bright),
        .hCount   (hCount),
        .vCount   (vCount),
        .Up       (Up),
        .Down     (Down),
        .Left     (Left),
        .Right    (Right),
        .rgb      (rgb),
        .score    (score)
    );

    always #20 clk = ~clk;

    // Monitor: whenever an expectation is pending, compare on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compared++;
            if (rgb !== e.rgb || score !== e.score) begin
                mismatched++;
                $display("[TB] FAIL %s: got rgb=%h score=%0d, want rgb=%h score=%0d",
                         e.name, rgb, score, e.rgb, e.score);
            end
        end
    end

    function automatic logic [9:0] cell_h(input int c);
        return 10'(144 + c * 40 + 20);
    endfunction

    function automatic logic [9:0] cell_v(input int r);
        return 10'(35 + r * 40 + 20);
    endfunction

    // One movement tick with the given buttons held throughout.
    task automatic applyStimulus(input logic [3:0] btn);
        @(negedge clk);
        {Up, Down, Left, Right} = btn;
        @(negedge clk);
        move_clk = 1'b1;
        repeat (3) @(negedge clk);
        move_clk = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pressOnce(input logic [3:0] btn);
        applyStimulus(btn);
        applyStimulus(BTN_NONE);
    endtask

    // Drive one pixel, let the DUT register it, then queue what it must show.
    task automatic checkOutput(input logic [9:0] h, input logic [9:0] v, input logic b,
                               input logic [11:0] exp_rgb, input logic [3:0] exp_score,
                               input string name);
        @(negedge clk);
        hCount = h;
        vCount = v;
        bright = b;
        @(posedge clk);
        #1;
        exp_q.push_back('{exp_rgb, exp_score, name});
    endtask

    task automatic checkPlayer(input int c, input int r, input logic [3:0] s, input string name);
        checkOutput(cell_h(c), cell_v(r), 1'b1, 12'hF00, s, name);
    endtask

    initial begin
        goal_path = '{'{BTN_DN, 2}, '{BTN_RT, 5}, '{BTN_DN, 2}, '{BTN_RT, 8}, '{BTN_DN, 2},
                      '{BTN_LF, 5}, '{BTN_DN, 2}, '{BTN_RT, 5}, '{BTN_DN, 1}};

        reset    = 1'b1;
        move_clk = 1'b0;
        bright   = 1'b0;
        hCount   = 10'd0;
        vCount   = 10'd0;
        {Up, Down, Left, Right} = BTN_NONE;
        repeat (2) @(negedge clk);
        checkOutput(10'd192, 10'd83, 1'b1, 12'h000, 4'd0, "reset_rgb");
        @(negedge clk);
        reset = 1'b0;
        checkOutput(10'd192, 10'd83, 1'b1, 12'hF00, 4'd0, "start_inner_corner");

        // Walls above and left of the start cell.
        pressOnce(BTN_UP);
        checkPlayer(1, 1, 4'd0, "up_blocked");
        pressOnce(BTN_LF);
        checkPlayer(1, 1, 4'd0, "left_blocked");
        checkOutput(10'd144, 10'd35, 1'b1, 12'h00F, 4'd0, "corner_wall");

        pressOnce(BTN_DN);
        checkPlayer(1, 2, 4'd0, "down_1_2");
        checkOutput(cell_h(1), cell_v(1), 1'b1, 12'hFFF, 4'd0, "start_vacated");
        pressOnce(BTN_DN);
        checkPlayer(1, 3, 4'd0, "down_1_3");
        pressOnce(BTN_DN);
        checkPlayer(1, 3, 4'd0, "down_blocked_1_4");

        pressOnce(BTN_UP | BTN_RT);
        checkPlayer(1, 2, 4'd0, "up_beats_right");
        checkOutput(cell_h(2), cell_v(3), 1'b1, 12'hFFF, 4'd0, "right_not_taken");
        pressOnce(BTN_DN);
        checkPlayer(1, 3, 4'd0, "back_to_1_3");

        for (int k = 0; k < 5; k++) applyStimulus(BTN_RT);
        applyStimulus(BTN_NONE);
        checkPlayer(2, 3, 4'd0, "held_right_once");
        checkOutput(cell_h(3), cell_v(3), 1'b1, 12'hFFF, 4'd0, "held_no_second_move");

        // Pixel boundaries with the player at (2,3): cell origin x=80, y=120.
        checkOutput(cell_h(2), cell_v(3), 1'b0, 12'h000, 4'd0, "blank_on_player");
        checkOutput(10'd232, 10'd163, 1'b1, 12'hF00, 4'd0, "inner_ox8_oy8");
        checkOutput(10'd255, 10'd186, 1'b1, 12'hF00, 4'd0, "inner_ox31_oy31");
        checkOutput(10'd256, 10'd163, 1'b1, 12'hFFF, 4'd0, "outer_ox32");
        checkOutput(10'd232, 10'd162, 1'b1, 12'hFFF, 4'd0, "outer_oy7");
        checkOutput(cell_h(14), cell_v(10), 1'b1, 12'h0F0, 4'd0, "goal_green");
        // (5,45) falls in cell (0,1), which the ROM marks as wall.
        checkOutput(10'd149, 10'd80, 1'b1, 12'h00F, 4'd0, "pixel_5_45");
        checkOutput(10'd229, 10'd80, 1'b1, 12'hFFF, 4'd0, "floor_2_1");
        checkOutput(10'd183, 10'd95, 1'b1, 12'h00F, 4'd0, "x39_wall");
        checkOutput(10'd184, 10'd95, 1'b1, 12'hFFF, 4'd0, "x40_floor");
        checkOutput(10'd783, 10'd514, 1'b1, 12'h00F, 4'd0, "last_pixel_wall");

        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checkPlayer(1, 1, 4'd0, "reset_returns_start");

        // Walk to the goal 17 times; the 16th wraps the score to zero.
        for (int g = 0; g < 17; g++) begin
            for (int l = 0; l < 9; l++) begin
                for (int k = 0; k < goal_path[l].steps; k++) pressOnce(goal_path[l].dir);
                if (g == 0 && l == 7) checkPlayer(14, 9, 4'd0, "before_goal");
            end
            checkPlayer(1, 1, 4'(g + 1), "goal_respawn");
            checkOutput(cell_h(14), cell_v(10), 1'b1, 12'h0F0, 4'(g + 1), "goal_after_score");
        end

        // Reset lands on the very edge where a Down tick is active.
        @(negedge clk);
        {Up, Down, Left, Right} = BTN_DN;
        @(negedge clk);
        move_clk = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        move_clk = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        {Up, Down, Left, Right} = BTN_NONE;
        checkPlayer(1, 1, 4'd0, "reset_overrides_tick");
        checkOutput(cell_h(1), cell_v(2), 1'b1, 12'hFFF, 4'd0, "no_move_under_reset");

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            $display("[TB] FAIL drain: got %0d pending, want 0", exp_q.size());
            mismatched += exp_q.size();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
